// File: rtl/ping_pong_rd.sv
`default_nettype none
// ============================================================================
//  Module      : ping_pong_rd
//  Description : Consumer side of a two-bank ping-pong buffer. Waits for the
//                expected bank to be marked full, reads it address by address
//                through a credit-limited pipeline into a 2-entry skid FIFO,
//                streams the words out on valid/ready and pulses a release for
//                the bank once its last word has been accepted downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module ping_pong_rd #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_release,
  output logic              ram_a_en,
  output logic [ADDR_W-1:0] ram_a_addr,
  input  logic [DATA_W-1:0] ram_a_dout,
  output logic              ram_b_en,
  output logic [ADDR_W-1:0] ram_b_addr,
  input  logic [DATA_W-1:0] ram_b_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              m_bank,
  output logic              err_ovr
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Control state
  logic [1:0]        r_state;
  logic              r_next_bank;
  logic              r_cur_bank;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [1:0]        r_release;
  logic              r_err_ovr;

  // One-deep read pipeline: a read issued last cycle returns data this cycle
  logic              r_inflight;
  logic              r_infl_last;

  // Two-entry skid FIFO holding returned words until accepted downstream
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [1:0]        w_credit;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_head_last;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_active;

  // Words already owed to the FIFO: stored entries plus the read on the way.
  assign w_credit    = r_count + {1'b0, r_inflight};
  assign m_valid     = (r_count != 2'd0);
  assign w_pop       = m_valid & m_ready;
  assign w_push      = r_inflight;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // A new read may start only if its word is guaranteed a FIFO slot, either
  // because there is spare room or because the head leaves this very cycle.
  assign w_issue = (r_state == c_ST_READ) && ((w_credit < 2'd2) || w_pop);

  // Only the bank being consumed drives its port; the other stays all-zero.
  assign ram_a_en   = w_issue & ~r_cur_bank;
  assign ram_b_en   = w_issue &  r_cur_bank;
  assign ram_a_addr = ram_a_en ? r_rd_addr : '0;
  assign ram_b_addr = ram_b_en ? r_rd_addr : '0;

  assign w_rd_data = r_cur_bank ? ram_b_dout : ram_a_dout;

  // Stream outputs are forced to zero whenever nothing is presented.
  assign m_data = m_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign m_last = m_valid & w_head_last;
  assign m_bank = m_valid & r_cur_bank;

  assign bank_release = r_release;
  assign err_ovr      = r_err_ovr;

  assign w_active = (r_state == c_ST_READ) || (r_state == c_ST_DRAIN);

  // Bank sequencing: wait for the expected bank, read it, drain, release it.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_next_bank <= 1'b0;
      r_cur_bank  <= 1'b0;
      r_rd_addr   <= '0;
      r_release   <= 2'b00;
    end else begin
      r_release <= 2'b00;
      case (r_state)
        c_ST_IDLE: begin
          // Only the bank whose turn it is can start, keeping strict A/B order.
          if (bank_full[r_next_bank]) begin
            r_cur_bank <= r_next_bank;
            r_rd_addr  <= '0;
            r_state    <= c_ST_READ;
          end
        end
        c_ST_READ: begin
          if (w_issue) begin
            if (r_rd_addr == c_LAST_ADDR) begin
              r_rd_addr <= '0;
              r_state   <= c_ST_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        c_ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_release   <= r_cur_bank ? 2'b10 : 2'b01;
            r_next_bank <= ~r_next_bank;
            r_state     <= c_ST_IDLE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Track the read issued this cycle so its data is captured next cycle.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_rd_addr == c_LAST_ADDR);
    end
  end

  // Skid FIFO: capture returning words, release them on handshake.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= 2'b00;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_rd_data;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: the writer withdrew the bank while it was still in use.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovr <= 1'b0;
    end else if (w_active && !bank_full[r_cur_bank]) begin
      r_err_ovr <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_pong_rd
//  Description : Scoreboard bench for ping_pong_rd with behavioural bank RAMs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_pong_rd;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk_100 = 1'b0;
  logic              rst_n;
  logic [1:0]        bank_full;
  logic [1:0]        bank_release;
  logic              ram_a_en, ram_b_en;
  logic [ADDR_W-1:0] ram_a_addr, ram_b_addr;
  logic [DATA_W-1:0] ram_a_dout = '0;
  logic [DATA_W-1:0] ram_b_dout = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_ready, m_last, m_bank, err_ovr;

  always #5 clk_100 = ~clk_100;

  ping_pong_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .bank_full(bank_full),
    .bank_release(bank_release),
    .ram_a_en(ram_a_en), .ram_a_addr(ram_a_addr), .ram_a_dout(ram_a_dout),
    .ram_b_en(ram_b_en), .ram_b_addr(ram_b_addr), .ram_b_dout(ram_b_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_bank(m_bank), .err_ovr(err_ovr)
  );

  // Bank contents: distinct arithmetic patterns per bank.
  function automatic logic [DATA_W-1:0] word_of(input logic b, input int a);
    if (!b) return DATA_W'((a * 3 + 1) & 15);
    return DATA_W'((a * 5 + 7) & 15);
  endfunction

  // Synchronous-read RAM models, one cycle latency.
  always @(posedge clk_100) begin
    if (ram_a_en) ram_a_dout <= word_of(1'b0, int'(ram_a_addr));
    if (ram_b_en) ram_b_dout <= word_of(1'b1, int'(ram_b_addr));
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [DATA_W+1:0] sb_q[$];
  int                acc_cnt = 0;
  int                rel_seen = 0;
  int                outstanding = 0;
  int                cyc = 0;
  int                t_first = -1;
  int                t_last = -1;
  logic [ADDR_W-1:0] exp_a = '0;
  logic [ADDR_W-1:0] exp_b = '0;
  logic              rel_due = 1'b0;
  logic [1:0]        exp_rel = 2'b00;
  logic              prev_stall = 1'b0;
  logic [DATA_W+1:0] prev_word = '0;
  logic              m_pop;
  logic [DATA_W+1:0] m_got, m_want;

  // Monitor: compares every accepted word, release pulse, port usage, credits.
  always @(negedge clk_100) begin
    cyc++;
    if (!rst_n) begin
      outstanding = 0;
      exp_a       = '0;
      exp_b       = '0;
      rel_due     = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      m_pop = m_valid && m_ready;
      m_got = {m_bank, m_last, m_data};

      if (rel_due) begin
        chk("release_pulse", bank_release, exp_rel);
        rel_due = 1'b0;
      end else if (bank_release != 2'b00) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_release: got %b expected 00 at %0t", bank_release, $time);
      end
      if (bank_release != 2'b00) rel_seen++;

      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_word", m_got, prev_word);
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = m_got;

      if (ram_a_en || ram_b_en) begin
        if (outstanding >= 2) chk("credit_pop", m_pop, 1);
        if (ram_a_en) begin
          chk("addr_a", ram_a_addr, exp_a);
          chk("unused_b", {ram_b_en, ram_b_addr}, 0);
          if (ram_a_addr == 0) t_first = cyc;
          if (ram_a_addr == ADDR_W'(DEPTH - 1)) t_last = cyc;
          exp_a = exp_a + 1'b1;
        end else begin
          chk("addr_b", ram_b_addr, exp_b);
          chk("unused_a", {ram_a_en, ram_a_addr}, 0);
          exp_b = exp_b + 1'b1;
        end
      end

      if (m_pop) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", m_got, $time);
        end else begin
          m_want = sb_q.pop_front();
          chk("stream_word", m_got, m_want);
          if (m_want[DATA_W]) begin
            rel_due = 1'b1;
            exp_rel = m_want[DATA_W+1] ? 2'b10 : 2'b01;
          end
        end
      end

      outstanding = outstanding + ((ram_a_en || ram_b_en) ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // Downstream ready: always-on, or random with occasional 20-cycle stalls.
  int rdy_mode   = 0;
  int stall_left = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk_100);
      #1;
      if (rdy_mode == 0) begin
        m_ready = 1'b1;
      end else if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        m_ready    = 1'b0;
        stall_left = 19;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic push_bank(input logic b);
    for (int i = 0; i < DEPTH; i++) sb_q.push_back({b, (i == DEPTH - 1), word_of(b, i)});
  endtask

  task automatic wait_rel(input int target, input int budget);
    int k;
    k = 0;
    while (rel_seen < target && k < budget) begin
      @(negedge clk_100);
      #1;
      k++;
    end
    chk("release_count", rel_seen, target);
  endtask

  task automatic wait_words(input int base, input int n, input int budget);
    int k;
    k = 0;
    while ((acc_cnt - base) < n && k < budget) begin
      @(negedge clk_100);
      #1;
      k++;
    end
    chk("words_reached", ((acc_cnt - base) >= n), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_bank"}, m_bank, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_release"}, bank_release, 0);
    chk({tag, "_ram_a"}, {ram_a_en, ram_a_addr}, 0);
    chk({tag, "_ram_b"}, {ram_b_en, ram_b_addr}, 0);
    chk({tag, "_err_ovr"}, err_ovr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_100);
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100);
    #1;
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  int base;
  int rel_t;

  initial begin
    rst_n     = 1'b0;
    bank_full = 2'b00;
    repeat (3) @(negedge clk_100);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Scenario 1: bank A, ready held high, latency and back-to-back issue
    @(negedge clk_100);
    #1;
    bank_full = 2'b01;
    push_bank(1'b0);
    @(negedge clk_100); #1; chk("s1_lat_c0", m_valid, 0);
    @(negedge clk_100); #1; chk("s1_lat_c1", m_valid, 0);
    @(negedge clk_100); #1; chk("s1_lat_c2", m_valid, 1);
    wait_rel(1, 3000);
    chk("s1_consecutive", t_last - t_first, DEPTH - 1);
    chk("s1_sb_empty", sb_q.size(), 0);

    // Scenario 2: both full, B then A in alternation
    bank_full = 2'b11;
    push_bank(1'b1);
    push_bank(1'b0);
    wait_rel(2, 3000);
    bank_full = 2'b01;
    wait_rel(3, 3000);
    bank_full = 2'b00;
    chk("s2_sb_empty", sb_q.size(), 0);
    chk("s2_err_ovr", err_ovr, 0);

    // Scenario 3: only B full after reset, nothing must happen
    do_reset();
    bank_full = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_100);
      #1;
      chk("s3_quiet", {m_valid, ram_a_en, ram_b_en}, 0);
    end
    bank_full = 2'b11;
    push_bank(1'b0);
    push_bank(1'b1);
    rel_t = rel_seen + 1;
    wait_rel(rel_t, 3000);
    bank_full = 2'b10;
    wait_rel(rel_t + 1, 3000);
    bank_full = 2'b00;
    chk("s3_sb_empty", sb_q.size(), 0);

    // Scenario 4: random backpressure
    do_reset();
    rdy_mode  = 1;
    bank_full = 2'b01;
    push_bank(1'b0);
    wait_rel(rel_seen + 1, 20000);
    bank_full = 2'b00;
    rdy_mode  = 0;
    chk("s4_sb_empty", sb_q.size(), 0);
    chk("s4_err_ovr", err_ovr, 0);

    // Scenario 5: full flag withdrawn mid-bank
    do_reset();
    bank_full = 2'b01;
    push_bank(1'b0);
    base = acc_cnt;
    wait_words(base, 500, 3000);
    chk("s5_err_before", err_ovr, 0);
    bank_full = 2'b00;
    @(negedge clk_100);
    #1;
    chk("s5_err_set", err_ovr, 1);
    wait_rel(rel_seen + 1, 3000);
    chk("s5_sb_empty", sb_q.size(), 0);
    repeat (5) @(negedge clk_100);
    #1;
    chk("s5_err_sticky", err_ovr, 1);

    // Scenario 6: reset in the middle of a transfer
    do_reset();
    chk("s6_err_cleared", err_ovr, 0);
    bank_full = 2'b01;
    push_bank(1'b0);
    base = acc_cnt;
    wait_words(base, 300, 3000);
    @(negedge clk_100);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("s6_async");
    repeat (3) @(negedge clk_100);
    #1;
    sb_q.delete();
    rel_t = rel_seen;
    rst_n = 1'b1;
    push_bank(1'b0);
    wait_rel(rel_t + 1, 3000);
    bank_full = 2'b00;
    chk("s6_sb_empty", sb_q.size(), 0);

    repeat (5) @(negedge clk_100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ping_pong_rd.md
Name: ping_pong_rd

Overview:
- Consumer side of the two-bank ping-pong buffer.
- The writer fills bank A or bank B and raises that bank's full flag. This block reads the full bank's read port address by address and streams the words out on a valid/ready interface.
- When the last word of a bank is accepted downstream, it pulses a release for that bank so the writer can refill it.
- Banks are always consumed in strict alternation, starting with A after reset.

Parameters:
- DATA_W, 4, width of a buffer word.
- ADDR_W, 10, RAM address width.
- DEPTH, 1024, words per bank; must be ≤ 2**ADDR_W and ≥ 2.

Ports:
- clk_100 input 1: single clock for all logic.
- rst_n input 1: asynchronous, active-low reset.
- bank_full input 2: level flags from the writer; bit0 = bank A holds DEPTH valid words, bit1 = bank B.
- bank_release output 2: one-cycle pulse per bank; bank has been fully consumed.
- ram_a_en output 1: read enable, bank A read port.
- ram_a_addr output ADDR_W: read address, bank A.
- ram_a_dout input DATA_W: read data, bank A; valid 1 cycle after ram_a_en.
- ram_b_en output 1: read enable, bank B read port.
- ram_b_addr output ADDR_W: read address, bank B.
- ram_b_dout input DATA_W: read data, bank B; valid 1 cycle after ram_b_en.
- m_data output DATA_W: stream data.
- m_valid output 1: stream valid.
- m_ready input 1: stream ready.
- m_last output 1: qualifies the final word of a bank.
- m_bank output 1: bank the current word came from; 0 = A, 1 = B.
- err_ovr output 1: sticky flag; the active bank's full flag dropped before release.

Behaviour:
- Reset values (async on rst_n low): state IDLE, next_bank = 0 (A), rd_addr = 0, skid FIFO empty, in-flight = 0.
- Outputs at reset: m_valid, m_last, m_bank, m_data, bank_release, ram_*_en, ram_*_addr and err_ovr are all 0.
- State IDLE:
  - If bank_full[next_bank] = 1, latch cur_bank = next_bank and go to READ.
  - The other bank's flag is ignored, so strict order holds.
- State READ: issue reads on cur_bank's port at rd_addr = 0..DEPTH-1, ascending.
  - Issue condition (credit rule): (fifo_count + inflight) < 2, OR (m_valid AND m_ready).
  - On issue, ram_x_en = 1 and rd_addr increments.
  - After issuing address DEPTH-1, go to DRAIN and reset rd_addr to 0.
  - The unused bank's en and addr stay 0.
- Read latency: the data word is captured into a 2-entry skid FIFO 1 cycle after issue.
  - The m_* signals come from the FIFO head.
  - Write and read of the FIFO in the same cycle are allowed.
- Throughput: 1 word/cycle while m_ready is held high.
- First-word latency: m_valid rises 2 cycles after bank_full[next_bank] is sampled high in IDLE.
- Backpressure: while m_valid = 1 and m_ready = 0, m_data, m_last and m_bank stay stable. No word is lost or duplicated, and the FIFO never overflows under the credit rule.
- m_last = 1 only on the word read from address DEPTH-1. m_bank equals cur_bank for every word of the bank.
- State DRAIN: no reads are issued. When the m_last word is accepted (m_valid & m_ready & m_last):
  - bank_release[cur_bank] = 1 for exactly the next cycle;
  - next_bank toggles;
  - go to IDLE.
- Next bank entry: bank_full[next_bank] is sampled in IDLE, so the earliest start of the next bank is the cycle after release.
- Overrun: if bank_full[cur_bank] = 0 in any READ or DRAIN cycle, err_ovr is set.
  - err_ovr is sticky until reset.
  - The transfer still completes normally.
- Reset mid-transfer: everything returns to the reset values immediately.
  - Partially streamed words are discarded and no release pulse is generated.
  - The next transfer starts from bank A at address 0.
- Address width: rd_addr is ADDR_W bits, and the terminal comparison is against DEPTH-1; there is no wrap past DEPTH-1.

Test Plan:
1. Reset, then bank_full = 01 with m_ready held 1 → ram_a_en for addresses 0..1023 on consecutive cycles.
   - m_valid is first seen 2 cycles after bank_full is sampled high in IDLE.
   - 1024 words in RAM-A order with m_bank = 0; m_last on word 1023 only.
   - bank_release = 01 for one cycle.
2. After scenario 1 with bank_full = 11 → bank B is read next; m_bank = 1, then bank_release = 10. Alternation continues A, B, A.
3. bank_full = 10 right after reset → no reads and m_valid stays 0 until bit0 rises, then bank A is read first.
4. Random m_ready (50%, including 20-cycle stalls) → all 1024 words delivered exactly once, in order. m_data is stable during every stall, and ram_a_en never fires when fifo_count + inflight = 2 without a pop.
5. bank_full[0] drops at word 500 of bank A → err_ovr = 1 from the next cycle and stays high. All 1024 words still stream and the release pulse occurs.
6. rst_n low at word 300 for 3 cycles → all outputs 0 asynchronously. After release, bank_full = 01 restarts at bank A address 0 with no bank_release from the aborted transfer.
